io_bus_arbiter: RTL and testbench
=================================

# io_bus_arbiter

Round-robin arbiter for the shared memory-mapped I/O bus (address bus, OR-combined data bus, write enable) that connects data memory, timer, key, switch, LEDR, LEDG and HEX devices. It grants one of up to NREQ masters (processor memory stage, DMA engine, debug port) at a time, muxes the owner's address, write data and write enable onto the bus, and broadcasts read data back. It enforces a hold limit so one master cannot starve the others.

## Interface
- NREQ, 3: number of requesting masters; index 0 is the processor.
- DBITS, 32: address and data width.
- MAX_HOLD, 16: grant cycles after which a waiting requester forces rotation; minimum 1.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-master bus request, level-sensitive.
- lock  in  NREQ  owner asks to keep the bus past MAX_HOLD; only the current owner's bit is used.
- addr_in  in  NREQ*DBITS  packed addresses, master i at [i*DBITS +: DBITS].
- wdata_in  in  NREQ*DBITS  packed write data.
- wren_in  in  NREQ  per-master write enable.
- rdata_in  in  DBITS  OR of all slave read buses.
- gnt  out  NREQ  registered one-hot grant; all zero when idle.
- abus  out  DBITS  address bus.
- dbus_out  out  DBITS  write-data contribution to the OR bus; zero unless a write is in progress.
- wren  out  1  bus write enable.
- rdata_out  out  DBITS  read data broadcast to all masters.
- busy  out  1  bus is granted.

## Operation
- FSM states are IDLE and OWNED. The owner index and hold_cnt are registered. The RR pointer holds the last owner.
- IDLE:
  - If any req bit is set, grant the first requester found searching from ptr+1 upward with wrap, then go to OWNED with hold_cnt = 0.
  - If no req bit is set, stay in IDLE.
- OWNED, each cycle:
  - If req[owner] is 0 and another req is set, hand over directly to the next requester in RR order after the owner. hold_cnt returns to 0.
  - If req[owner] is 0 and no other req is set, go to IDLE with gnt = 0.
  - If req[owner] is 1, another requester is waiting, hold_cnt == MAX_HOLD-1 and lock[owner] is 0, force a handover to the next requester.
  - Otherwise the owner keeps the bus. hold_cnt increments and saturates at MAX_HOLD-1.
- On every new grant, ptr takes the value of the new owner.
- Bus outputs are combinational from the registered gnt:
  - abus = addr_in[owner] when busy, else 0.
  - wren = busy & wren_in[owner].
  - dbus_out = wren ? wdata_in[owner] : 0.
- rdata_out = rdata_in, unfiltered. A master qualifies read data with its own gnt.
- A req bit from a master that is not the owner has no effect on the bus.

## Timing
- Reset, asynchronous:
  - gnt = 0, state IDLE, ptr = NREQ-1 (so the first search starts at master 0), hold_cnt = 0.
  - abus, dbus_out and wren are 0 immediately because they are derived from gnt.
- Grant latency: a req sampled at edge k gives gnt high after edge k; the first bus cycle follows that edge.
- Release: when req drops before edge k, gnt changes at edge k. The cycle before edge k is still owned, and any write in that cycle completes.
- Handover from A to B happens at a single edge with no dead cycle. Both gnt bits are never set in the same cycle.
- Hold limit: at most MAX_HOLD consecutive owned cycles while another master waits, unless the owner holds lock.
- If req and lock drop together, release takes priority.
- Reset asserted mid-write: the write is aborted and wren falls asynchronously.

## Structure
- Shared package `bus_pkg` holds:
  - the state enum (IDLE, OWNED);
  - the device address constants: KEY F0000010, SW F0000014, HEX F0000000, LEDR F0000004, LEDG F0000008;
  - the default DBITS.
- Sub-module `rr_pick` is a combinational rotating priority encoder. Inputs are a request vector and a start index. Outputs are the one-hot winner and a valid flag. It is instantiated once.
- Bus muxing is an AND-OR over the gnt bits. No priority mux chain is used.

## Test plan
- Reset then req=001 with addr0=F0000004, wren0=1, wdata0=0x3FF: gnt=001 after one edge, abus=F0000004, wren=1, dbus_out=0x3FF; gnt=000 one edge after req drops.
- req=111 held continuously with MAX_HOLD=4, lock=0: gnt sequence 001×4, 010×4, 100×4, then 001; never two bits set at once; no idle cycle between owners.
- req=011 with lock[0]=1 for 20 cycles: gnt stays 001 the whole time; lock drops → gnt=010 within one edge.
- Master 1 owns the bus, req1 drops while req2=1: gnt goes 010 → 100 at one edge; ptr=2; next contention with req=011 grants master 0.
- Assert reset mid-write while gnt=010: gnt, wren, abus and dbus_out read 0 before the next clk edge; after deassert with req=000 the bus stays idle and busy=0.
- req bit pulses for one cycle only: gnt asserts for exactly one cycle and falls at the following edge; the wren of a non-owner never reaches the bus.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the memory-mapped I/O bus: arbiter state encoding,
// device address map and the default bus width.
package bus_pkg;

   typedef enum logic {
      IDLE,
      OWNED
   } state_t;

   localparam int DEFAULT_DBITS = 32;

   localparam logic [31:0] ADDR_HEX  = 32'hF000_0000;
   localparam logic [31:0] ADDR_LEDR = 32'hF000_0004;
   localparam logic [31:0] ADDR_LEDG = 32'hF000_0008;
   localparam logic [31:0] ADDR_KEY  = 32'hF000_0010;
   localparam logic [31:0] ADDR_SW   = 32'hF000_0014;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: returns the first set request bit
// found from i_start upward with wrap-around, as a one-hot vector.
module rr_pick #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_start,
   output logic [N-1:0]  o_winner,
   output logic          o_valid
);

   always_comb begin
      o_winner = '0;
      o_valid  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!o_valid && i_req[IW'((int'(i_start) + i) % N)]) begin
            o_winner[IW'((int'(i_start) + i) % N)] = 1'b1;
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin owner arbitration for the shared I/O bus with a hold limit,
// plus AND-OR muxing of the owner's address/write data onto the bus.
module io_bus_arbiter
   import bus_pkg::*;
#(
   parameter int NREQ     = 3,
   parameter int DBITS    = DEFAULT_DBITS,
   parameter int MAX_HOLD = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       lock,
   input  logic [NREQ*DBITS-1:0] addr_in,
   input  logic [NREQ*DBITS-1:0] wdata_in,
   input  logic [NREQ-1:0]       wren_in,
   input  logic [DBITS-1:0]      rdata_in,
   output logic [NREQ-1:0]       gnt,
   output logic [DBITS-1:0]      abus,
   output logic [DBITS-1:0]      dbus_out,
   output logic                  wren,
   output logic [DBITS-1:0]      rdata_out,
   output logic                  busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   state_t           r_state;
   logic [NREQ-1:0]  r_gnt;
   logic [IW-1:0]    r_owner;
   logic [IW-1:0]    r_ptr;
   logic [HW-1:0]    r_hold;

   logic [IW-1:0]    w_start;
   logic [NREQ-1:0]  w_mask;
   logic [NREQ-1:0]  w_winner;
   logic             w_valid;
   logic [IW-1:0]    w_winIdx;

   // The owner is masked out so the search only finds a different master;
   // in IDLE r_gnt is zero and every request is eligible.
   assign w_start = (r_ptr == LAST_IDX) ? '0 : r_ptr + 1'b1;
   assign w_mask  = req & ~r_gnt;

   rr_pick #(
      .N  (NREQ),
      .IW (IW)
   ) u_pick (
      .i_req    (w_mask),
      .i_start  (w_start),
      .o_winner (w_winner),
      .o_valid  (w_valid)
   );

   always_comb begin
      w_winIdx = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (w_winner[j]) w_winIdx = IW'(j);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_owner <= '0;
         r_ptr   <= LAST_IDX;
         r_hold  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_state <= OWNED;
                  r_gnt   <= w_winner;
                  r_owner <= w_winIdx;
                  r_ptr   <= w_winIdx;
                  r_hold  <= '0;
               end
            end
            OWNED: begin
               if (!req[r_owner]) begin
                  r_hold <= '0;
                  if (w_valid) begin
                     r_gnt   <= w_winner;
                     r_owner <= w_winIdx;
                     r_ptr   <= w_winIdx;
                  end else begin
                     r_state <= IDLE;
                     r_gnt   <= '0;
                  end
               end else if (w_valid && (r_hold == HOLD_LAST) && !lock[r_owner]) begin
                  r_gnt   <= w_winner;
                  r_owner <= w_winIdx;
                  r_ptr   <= w_winIdx;
                  r_hold  <= '0;
               end else if (r_hold != HOLD_LAST) begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_gnt   <= '0;
            end
         endcase
      end
   end

   // AND-OR bus mux keyed directly on the registered one-hot grant, so the
   // bus clears as soon as the grant does (including on asynchronous reset).
   always_comb begin
      abus     = '0;
      dbus_out = '0;
      wren     = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         abus     = abus | (addr_in[j*DBITS +: DBITS] & {DBITS{r_gnt[j]}});
         dbus_out = dbus_out | (wdata_in[j*DBITS +: DBITS] & {DBITS{r_gnt[j] & wren_in[j]}});
         wren     = wren | (r_gnt[j] & wren_in[j]);
      end
   end

   assign gnt       = r_gnt;
   assign busy      = |r_gnt;
   assign rdata_out = rdata_in;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed self-checking bench for io_bus_arbiter (NREQ=3, DBITS=32, MAX_HOLD=4).
module tb_io_bus_arbiter;

   logic        clk;
   logic        reset;
   logic [2:0]  req;
   logic [2:0]  lock;
   logic [95:0] addrIn;
   logic [95:0] wdataIn;
   logic [2:0]  wrenIn;
   logic [31:0] rdataIn;
   logic [2:0]  gnt;
   logic [31:0] abus;
   logic [31:0] dbusOut;
   logic        wren;
   logic [31:0] rdataOut;
   logic        busy;

   int compared   = 0;
   int mismatched = 0;

   io_bus_arbiter #(
      .NREQ     (3),
      .DBITS    (32),
      .MAX_HOLD (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .lock      (lock),
      .addr_in   (addrIn),
      .wdata_in  (wdataIn),
      .wren_in   (wrenIn),
      .rdata_in  (rdataIn),
      .gnt       (gnt),
      .abus      (abus),
      .dbus_out  (dbusOut),
      .wren      (wren),
      .rdata_out (rdataOut),
      .busy      (busy)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] reqV, input logic [2:0] lockV);
      req  = reqV;
      lock = lockV;
   endtask

   task automatic applyReset();
      reset = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Directed sequence; all inputs change 1 ns after a rising edge.
   initial begin
      reset   = 1'b0;
      req     = '0;
      lock    = '0;
      addrIn  = '0;
      wdataIn = '0;
      wrenIn  = '0;
      rdataIn = 32'h0000_A5A5;
      #12;
      checkOutput("resetGnt", {29'd0, gnt}, 32'd0);
      checkOutput("resetAbus", abus, 32'd0);
      checkOutput("resetWren", {31'd0, wren}, 32'd0);
      checkOutput("resetDbus", dbusOut, 32'd0);
      checkOutput("resetBusy", {31'd0, busy}, 32'd0);
      reset = 1'b1;

      $display("[TB] single write by master 0");
      addrIn[0 +: 32]  = 32'hF000_0004;
      wdataIn[0 +: 32] = 32'h0000_03FF;
      wrenIn           = 3'b001;
      applyStimulus(3'b001, 3'b000);
      tick();
      checkOutput("grant0", {29'd0, gnt}, 32'd1);
      checkOutput("abus0", abus, 32'hF000_0004);
      checkOutput("wren0", {31'd0, wren}, 32'd1);
      checkOutput("dbus0", dbusOut, 32'h0000_03FF);
      checkOutput("rdata", rdataOut, 32'h0000_A5A5);
      applyStimulus(3'b000, 3'b000);
      tick();
      checkOutput("release0", {29'd0, gnt}, 32'd0);
      checkOutput("releaseWren", {31'd0, wren}, 32'd0);

      $display("[TB] rotation under full contention");
      wrenIn = '0;
      applyReset();
      applyStimulus(3'b111, 3'b000);
      for (int i = 0; i < 12; i++) begin
         tick();
         checkOutput("rotate", {29'd0, gnt}, 32'd1 << (i / 4));
         checkOutput("rotateBusy", {31'd0, busy}, 32'd1);
      end
      tick();
      checkOutput("rotateWrap", {29'd0, gnt}, 32'd1);

      $display("[TB] lock extends ownership");
      applyStimulus(3'b011, 3'b001);
      for (int i = 0; i < 20; i++) begin
         tick();
         checkOutput("locked", {29'd0, gnt}, 32'd1);
      end
      applyStimulus(3'b011, 3'b000);
      tick();
      checkOutput("unlock", {29'd0, gnt}, 32'd2);

      $display("[TB] direct handover on release");
      applyStimulus(3'b100, 3'b000);
      tick();
      checkOutput("handover12", {29'd0, gnt}, 32'd4);
      applyStimulus(3'b011, 3'b000);
      tick();
      checkOutput("ptrAfter2", {29'd0, gnt}, 32'd1);

      $display("[TB] reset during a write");
      addrIn[32 +: 32]  = 32'hF000_0014;
      wdataIn[32 +: 32] = 32'h0000_DEAD;
      wrenIn            = 3'b010;
      applyStimulus(3'b010, 3'b000);
      tick();
      checkOutput("owner1", {29'd0, gnt}, 32'd2);
      checkOutput("abus1", abus, 32'hF000_0014);
      checkOutput("dbus1", dbusOut, 32'h0000_DEAD);
      #3;
      reset = 1'b0;
      #1;
      checkOutput("abortGnt", {29'd0, gnt}, 32'd0);
      checkOutput("abortWren", {31'd0, wren}, 32'd0);
      checkOutput("abortAbus", abus, 32'd0);
      checkOutput("abortDbus", dbusOut, 32'd0);
      applyStimulus(3'b000, 3'b000);
      #2;
      reset = 1'b1;
      tick();
      tick();
      checkOutput("idleBusy", {31'd0, busy}, 32'd0);
      checkOutput("idleGnt", {29'd0, gnt}, 32'd0);

      $display("[TB] one-cycle request pulse, non-owner writes");
      addrIn[64 +: 32] = 32'hF000_0010;
      wrenIn           = 3'b011;
      applyStimulus(3'b100, 3'b000);
      tick();
      applyStimulus(3'b000, 3'b000);
      checkOutput("pulseGnt", {29'd0, gnt}, 32'd4);
      checkOutput("pulseAbus", abus, 32'hF000_0010);
      checkOutput("nonOwnerWren", {31'd0, wren}, 32'd0);
      checkOutput("nonOwnerDbus", dbusOut, 32'd0);
      tick();
      checkOutput("pulseFall", {29'd0, gnt}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
